pov_spi_tx: RTL
===============

// Module: pov_spi_tx
// PURPOSE
//  - SPI master that serialises one POV frame (playerX/Y, facingX/Y, vplaneX/Y) to the rbzero SPI vector-load port.
//  - Used by the FPGA/test-harness top level to drive i_sclk/i_mosi/i_ss_n from locally held vectors.
//  - The frame is double-buffered on the receiving side, which loads it at visible_frame_end.
// PARAMETERS
//  - F_BITS   24  width of one fixed-point word; must equal the width of `F in fixed_point_params.v
//  - CLK_DIV  2   SCLK half-period in clk cycles; legal range >=1
// PORTS
//  - clk                  in   1         system clock; all logic on rising edge
//  - reset                in   1         synchronous, active-high
//  - i_start              in   1         request one frame; sampled only while o_busy=0
//  - i_playerX..i_vplaneY in   F_BITS x6 vectors; captured on the accepted-start edge
//  - o_busy               out  1         high from the cycle after accept until the frame completes
//  - o_done               out  1         one-cycle pulse on frame completion
//  - o_sclk               out  1         SPI clock; idles low (mode 0)
//  - o_mosi               out  1         SPI data; changes on SCLK falling edges, stable at SCLK rise
//  - o_ss_n               out  1         active-low frame select
// BEHAVIOUR
//  - Reset: o_ss_n=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, FSM=IDLE.
//    Reset mid-frame aborts immediately; receiver discards the partial frame because ss_n rises.
//  - Payload: B = 6*F_BITS bits, order playerX, playerY, facingX, facingY, vplaneX, vplaneY, each MSB first.
//    Payload is held in one B-bit shift register loaded at accept; input changes after accept are ignored.
//  - FSM states and exits:
//    - IDLE: exit on i_start.
//    - SHIFT: ends after bit B-1's falling edge.
//    - HOLD: CLK_DIV cycles, then ss_n rises.
//    - back to IDLE.
//  - Timing (accept edge = cycle 0):
//    - cycle 1: o_ss_n=0, o_busy=1, o_mosi=bit B-1.
//    - bit k (k=0 is first sent) SCLK rise at cycle 1+CLK_DIV+2k*CLK_DIV; fall at 1+2(k+1)*CLK_DIV; mosi advances on the fall.
//    - After the last fall, mosi is driven 0.
//    - cycle 1+2*B*CLK_DIV+CLK_DIV: o_ss_n=1, o_busy=0, o_done=1 (same cycle).
//  - i_start while busy is ignored, not queued.
//  - i_start in the cycle o_done=1 is accepted (busy already low); the next frame's ss_n falls the following cycle.
//    Minimum ss_n-high time is therefore 1 cycle, which the receiver tolerates.
//  - Counters:
//    - div counter $clog2(CLK_DIV+1) bits; bit counter $clog2(B+1) bits; both reset to 0 and carry no wrap.
//    - No arithmetic on payload values.
// CONFIGURATION
//  - POV_SPI_TX_CHANGED_ONLY_EN defined:
//    - keeps a B-bit shadow of the last completed frame, cleared to 0 on reset;
//    - an accepted i_start whose inputs equal the shadow skips the frame: no ss_n activity, o_done pulses at cycle 1, o_busy stays 0;
//    - the shadow updates only on normal completion, never on an aborted frame.
//  - Macro undefined: every accepted start sends a full frame; no shadow register.
// STRUCTURE
//  - Shared include (alongside fixed_point_params.v):
//    - POV_WORDS=6;
//    - FSM state encodings (IDLE/SHIFT/HOLD) as localparams;
//    - the receiver uses the same word order/count from this include.
//  - One sub-module, spi_tx_serdes: generic SCLK divider + MSB-first shifter (parameters WIDTH, CLK_DIV).
//    - pov_spi_tx owns frame assembly, start/done handshake and the optional shadow compare.
// TESTING
//  - Reset then idle 100 cycles -> ss_n=1, sclk=0, mosi=0, busy=0, done never pulses.
//  - CLK_DIV=2, F_BITS=24, playerX=24'h123456, others distinct; start at cycle 0 ->
//    ss_n low at cycle 1, first SCLK rise at cycle 3, 144 rises total, done at cycle 579;
//    bench SPI model reconstructs all six words exactly.
//  - Loopback into rbzero pov: send frame, pulse load_if_ready -> pov outputs equal the sent vectors.
//  - Start pulsed at cycles 50 and 300 during a frame -> ignored; start held high through done -> second frame's ss_n falls the cycle after done.
//  - Reset asserted at cycle 200 mid-frame -> next cycle ss_n=1, sclk=0, busy=0, no done; a following start sends a complete frame.
//  - With POV_SPI_TX_CHANGED_ONLY_EN:
//    - frame A sent, start again with A -> done at cycle 1, no ss_n activity;
//    - then vplaneY changed -> full frame sent.

Source files
------------

// File: rtl/pov_spi_tx_pkg.sv
// Shared POV SPI definitions: word count and FSM encodings.
// Used by the transmitter and the rbzero-side receiver.
package pov_spi_tx_pkg;

  localparam int POV_WORDS = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    HOLD  = ST_HOLD
  } tx_state_e;

endpackage

// File: rtl/spi_tx_serdes.sv
// Generic SPI mode-0 SCLK divider and MSB-first shifter.
// Ports: clk, reset, load/data (start), run, shift_en, tick,
// last_fall, sclk, mosi.
module spi_tx_serdes #(
  parameter int WIDTH   = 144,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             run,
  input  logic             shift_en,
  output logic             tick,
  output logic             last_fall,
  output logic             sclk,
  output logic             mosi
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_END = BW'(WIDTH - 1);

  logic [DW-1:0]    div_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] sreg_q;
  logic             fall;

  // tick marks the end of one SCLK half-period
  assign tick      = run && (div_q == DIV_END);
  assign fall      = tick && shift_en && sclk;
  assign last_fall = fall && (bit_q == BIT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      bit_q  <= '0;
      sreg_q <= '0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
    end else if (load) begin
      // first bit goes out with ss_n, before any SCLK edge
      div_q  <= '0;
      bit_q  <= '0;
      sclk   <= 1'b0;
      mosi   <= data[WIDTH-1];
      sreg_q <= data << 1;
    end else if (run) begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick && shift_en) begin
        sclk <= ~sclk;
      end
      if (fall) begin
        mosi   <= last_fall ? 1'b0 : sreg_q[WIDTH-1];
        sreg_q <= sreg_q << 1;
        bit_q  <= bit_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pov_spi_tx.sv
// SPI master sending one POV frame (player/facing/vplane X,Y).
// Ports: clk, reset, i_start, i_playerX..i_vplaneY, o_busy,
// o_done, o_sclk, o_mosi, o_ss_n.
// Option: POV_SPI_TX_CHANGED_ONLY_EN skips unchanged frames.
module pov_spi_tx
  import pov_spi_tx_pkg::*;
#(
  parameter int F_BITS  = 24,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [F_BITS-1:0] i_playerX,
  input  logic [F_BITS-1:0] i_playerY,
  input  logic [F_BITS-1:0] i_facingX,
  input  logic [F_BITS-1:0] i_facingY,
  input  logic [F_BITS-1:0] i_vplaneX,
  input  logic [F_BITS-1:0] i_vplaneY,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_ss_n
);

  localparam int B = POV_WORDS * F_BITS;

  tx_state_e      state_q;
  tx_state_e      state_d;
  logic [B-1:0]   frame;
  logic           load;
  logic           done_d;
  logic           skip;
  logic           tick;
  logic           last_fall;

  assign frame = {i_playerX, i_playerY,
                  i_facingX, i_facingY,
                  i_vplaneX, i_vplaneY};

`ifdef POV_SPI_TX_CHANGED_ONLY_EN
  logic [B-1:0] shadow_q;
  logic [B-1:0] pend_q;

  assign skip = (frame == shadow_q);

  // pend_q commits only when a frame finishes normally
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      pend_q   <= '0;
    end else begin
      if (load) begin
        pend_q <= frame;
      end
      if (state_q == HOLD && tick) begin
        shadow_q <= pend_q;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (skip) begin
            done_d = 1'b1;
          end else begin
            state_d = SHIFT;
            load    = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (last_fall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      o_ss_n  <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_ss_n  <= (state_d == IDLE);
      o_busy  <= (state_d != IDLE);
      o_done  <= done_d;
    end
  end

  spi_tx_serdes #(
    .WIDTH   (B),
    .CLK_DIV (CLK_DIV)
  ) u_serdes (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data      (frame),
    .run       (state_q != IDLE),
    .shift_en  (state_q == SHIFT),
    .tick      (tick),
    .last_fall (last_fall),
    .sclk      (o_sclk),
    .mosi      (o_mosi)
  );

endmodule
